// File: rtl/line_list_pkg.sv
// Shared types and constants for the double-buffered line display list.
package line_list_pkg;

  typedef enum logic [1:0] {FILL, PENDING, COPY} list_state_t;

  // Every slot field (coordinates and visible flag) resets to this value.
  localparam int unsigned SLOT_FIELD_RST = 0;

endpackage

// File: rtl/line_list_bank.sv
// Two-bank slot register file: one write port and one copy port into the back bank,
// with the front bank flattened onto the renderer endpoint buses.
module line_list_bank
  import line_list_pkg::*;
#(
  parameter int n_lines = 8,
  parameter int w_x     = 10,
  parameter int w_y     = 9,
  parameter int w_idx   = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   front,
  input  logic                   we,
  input  logic [w_idx-1:0]       wr_idx,
  input  logic [w_x-1:0]         wr_x1,
  input  logic [w_y-1:0]         wr_y1,
  input  logic [w_x-1:0]         wr_x2,
  input  logic [w_y-1:0]         wr_y2,
  input  logic                   wr_en,
  input  logic                   cp_en,
  input  logic [w_idx-1:0]       cp_idx,
  output logic [n_lines*w_x-1:0] line_x1,
  output logic [n_lines*w_x-1:0] line_x2,
  output logic [n_lines*w_y-1:0] line_y1,
  output logic [n_lines*w_y-1:0] line_y2,
  output logic [n_lines-1:0]     line_en
);

  logic [w_x-1:0] x1_q [2][n_lines];
  logic [w_x-1:0] x2_q [2][n_lines];
  logic [w_y-1:0] y1_q [2][n_lines];
  logic [w_y-1:0] y2_q [2][n_lines];
  logic           en_q [2][n_lines];

  logic back;
  assign back = ~front;

  // Writes and copies only ever target the back bank, so the front bank
  // seen by the renderers is frozen for the whole frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < n_lines; i++) begin
          x1_q[b][i] <= w_x'(SLOT_FIELD_RST);
          x2_q[b][i] <= w_x'(SLOT_FIELD_RST);
          y1_q[b][i] <= w_y'(SLOT_FIELD_RST);
          y2_q[b][i] <= w_y'(SLOT_FIELD_RST);
          en_q[b][i] <= 1'(SLOT_FIELD_RST);
        end
      end
    end else if (we) begin
      x1_q[back][wr_idx] <= wr_x1;
      x2_q[back][wr_idx] <= wr_x2;
      y1_q[back][wr_idx] <= wr_y1;
      y2_q[back][wr_idx] <= wr_y2;
      en_q[back][wr_idx] <= wr_en;
    end else if (cp_en) begin
      x1_q[back][cp_idx] <= x1_q[front][cp_idx];
      x2_q[back][cp_idx] <= x2_q[front][cp_idx];
      y1_q[back][cp_idx] <= y1_q[front][cp_idx];
      y2_q[back][cp_idx] <= y2_q[front][cp_idx];
      en_q[back][cp_idx] <= en_q[front][cp_idx];
    end
  end

  always_comb begin
    line_x1 = '0;
    line_x2 = '0;
    line_y1 = '0;
    line_y2 = '0;
    line_en = '0;
    for (int i = 0; i < n_lines; i++) begin
      line_x1[i*w_x +: w_x] = x1_q[front][i];
      line_x2[i*w_x +: w_x] = x2_q[front][i];
      line_y1[i*w_y +: w_y] = y1_q[front][i];
      line_y2[i*w_y +: w_y] = y2_q[front][i];
      line_en[i]            = en_q[front][i];
    end
  end

endmodule

// File: rtl/line_list_ctrl.sv
// Display-list controller: fill the back bank, publish it on commit at the next
// frame boundary, then copy the new front bank back so later edits are incremental.
module line_list_ctrl
  import line_list_pkg::*;
#(
  parameter int screen_width  = 640,
  parameter int screen_height = 480,
  parameter int w_x           = $clog2(screen_width),
  parameter int w_y           = $clog2(screen_height),
  parameter int n_lines       = 8,
  parameter int w_idx         = $clog2(n_lines)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_end,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [w_idx-1:0]       wr_idx,
  input  logic [w_x-1:0]         wr_x1,
  input  logic [w_x-1:0]         wr_x2,
  input  logic [w_y-1:0]         wr_y1,
  input  logic [w_y-1:0]         wr_y2,
  input  logic                   wr_en,
  input  logic                   commit,
  output logic                   pending,
  output logic                   swap_done,
  output logic [n_lines*w_x-1:0] line_x1,
  output logic [n_lines*w_x-1:0] line_x2,
  output logic [n_lines*w_y-1:0] line_y1,
  output logic [n_lines*w_y-1:0] line_y2,
  output logic [n_lines-1:0]     line_en
);

  function automatic logic [w_x-1:0] clamp_x(input logic [w_x-1:0] v);
    return (int'(v) > screen_width - 1) ? w_x'(screen_width - 1) : v;
  endfunction

  function automatic logic [w_y-1:0] clamp_y(input logic [w_y-1:0] v);
    return (int'(v) > screen_height - 1) ? w_y'(screen_height - 1) : v;
  endfunction

  list_state_t      state;
  logic             front;
  logic [w_idx-1:0] cnt;
  logic             we;
  logic             cp_en;

  // Out-of-range slot indices still complete the handshake; the data is dropped.
  assign we    = wr_valid & wr_ready & (int'(wr_idx) < n_lines);
  assign cp_en = (state == COPY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      front     <= 1'b0;
      cnt       <= '0;
      wr_ready  <= 1'b1;
      pending   <= 1'b0;
      swap_done <= 1'b0;
    end else begin
      swap_done <= 1'b0;
      case (state)
        FILL: begin
          if (commit) begin
            state    <= PENDING;
            wr_ready <= 1'b0;
            pending  <= 1'b1;
          end
        end
        PENDING: begin
          if (frame_end) begin
            front     <= ~front;
            swap_done <= 1'b1;
            pending   <= 1'b0;
            cnt       <= '0;
            state     <= COPY;
          end
        end
        COPY: begin
          if (cnt == w_idx'(n_lines - 1)) begin
            cnt      <= '0;
            wr_ready <= 1'b1;
            state    <= FILL;
          end else begin
            cnt <= cnt + w_idx'(1);
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  line_list_bank #(
    .n_lines(n_lines),
    .w_x    (w_x),
    .w_y    (w_y),
    .w_idx  (w_idx)
  ) u_bank (
    .clk    (clk),
    .rst    (rst),
    .front  (front),
    .we     (we),
    .wr_idx (wr_idx),
    .wr_x1  (clamp_x(wr_x1)),
    .wr_y1  (clamp_y(wr_y1)),
    .wr_x2  (clamp_x(wr_x2)),
    .wr_y2  (clamp_y(wr_y2)),
    .wr_en  (wr_en),
    .cp_en  (cp_en),
    .cp_idx (cnt),
    .line_x1(line_x1),
    .line_x2(line_x2),
    .line_y1(line_y1),
    .line_y2(line_y2),
    .line_en(line_en)
  );

endmodule

// File: tb/tb_line_list_ctrl.sv
// Bench for line_list_ctrl: directed scenarios plus randomized traffic against a
// model that tracks "staged" and "on screen" line lists.
module tb_line_list_ctrl;

  localparam int N  = 8;
  localparam int WX = 10;
  localparam int WY = 9;
  localparam int SW = 640;
  localparam int SH = 480;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_end;
  logic          wr_valid;
  logic          wr_ready;
  logic [2:0]    wr_idx;
  logic [WX-1:0] wr_x1, wr_x2;
  logic [WY-1:0] wr_y1, wr_y2;
  logic          wr_en;
  logic          commit;
  logic          pending;
  logic          swap_done;
  logic [N*WX-1:0] line_x1, line_x2;
  logic [N*WY-1:0] line_y1, line_y2;
  logic [N-1:0]    line_en;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: staged list (what the next commit publishes) and screen list.
  int st_x1[N], st_x2[N], st_y1[N], st_y2[N], st_en[N];
  int sc_x1[N], sc_x2[N], sc_y1[N], sc_y2[N], sc_en[N];
  int m_mode;   // 0 accepting writes, 1 waiting for frame end, 2 busy after swap
  int m_busy;
  int m_swap;

  line_list_ctrl dut (
    .clk(clk), .rst(rst), .frame_end(frame_end),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx),
    .wr_x1(wr_x1), .wr_x2(wr_x2), .wr_y1(wr_y1), .wr_y2(wr_y2), .wr_en(wr_en),
    .commit(commit), .pending(pending), .swap_done(swap_done),
    .line_x1(line_x1), .line_x2(line_x2), .line_y1(line_y1), .line_y2(line_y2),
    .line_en(line_en)
  );

  always #5 clk = ~clk;

  function automatic logic [N*WX-1:0] exp_x1();
    logic [N*WX-1:0] v;
    for (int i = 0; i < N; i++) v[i*WX +: WX] = WX'(sc_x1[i]);
    return v;
  endfunction
  function automatic logic [N*WX-1:0] exp_x2();
    logic [N*WX-1:0] v;
    for (int i = 0; i < N; i++) v[i*WX +: WX] = WX'(sc_x2[i]);
    return v;
  endfunction
  function automatic logic [N*WY-1:0] exp_y1();
    logic [N*WY-1:0] v;
    for (int i = 0; i < N; i++) v[i*WY +: WY] = WY'(sc_y1[i]);
    return v;
  endfunction
  function automatic logic [N*WY-1:0] exp_y2();
    logic [N*WY-1:0] v;
    for (int i = 0; i < N; i++) v[i*WY +: WY] = WY'(sc_y2[i]);
    return v;
  endfunction
  function automatic logic [N-1:0] exp_en();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = (sc_en[i] != 0);
    return v;
  endfunction

  // One clock edge; the model consumes the same inputs the DUT sampled.
  task automatic tick();
    @(posedge clk);
    m_swap = 0;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        st_x1[i] = 0; st_x2[i] = 0; st_y1[i] = 0; st_y2[i] = 0; st_en[i] = 0;
        sc_x1[i] = 0; sc_x2[i] = 0; sc_y1[i] = 0; sc_y2[i] = 0; sc_en[i] = 0;
      end
      m_mode = 0;
      m_busy = 0;
    end else if (m_mode == 0) begin
      if (wr_valid && int'(wr_idx) < N) begin
        st_x1[wr_idx] = (int'(wr_x1) > SW - 1) ? SW - 1 : int'(wr_x1);
        st_x2[wr_idx] = (int'(wr_x2) > SW - 1) ? SW - 1 : int'(wr_x2);
        st_y1[wr_idx] = (int'(wr_y1) > SH - 1) ? SH - 1 : int'(wr_y1);
        st_y2[wr_idx] = (int'(wr_y2) > SH - 1) ? SH - 1 : int'(wr_y2);
        st_en[wr_idx] = int'(wr_en);
      end
      if (commit) m_mode = 1;
    end else if (m_mode == 1) begin
      if (frame_end) begin
        // After the post-swap copy the staged list equals the screen, so it stays as is.
        sc_x1 = st_x1; sc_x2 = st_x2; sc_y1 = st_y1; sc_y2 = st_y2; sc_en = st_en;
        m_mode = 2;
        m_busy = N;
        m_swap = 1;
      end
    end else begin
      m_busy--;
      if (m_busy == 0) m_mode = 0;
    end
    #1;
  endtask

  task automatic drive_write(input int idx, input int x1, input int y1,
                             input int x2, input int y2, input int en);
    wr_valid = 1'b1;
    wr_idx = 3'(idx);
    wr_x1 = WX'(x1); wr_y1 = WY'(y1); wr_x2 = WX'(x2); wr_y2 = WY'(y2);
    wr_en = 1'(en);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic pulse_frame_end();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
  endtask

  task automatic wait_fill();
    int k = 0;
    while (wr_ready !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    if (wr_ready !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_fill timeout wr_ready=%b required 1", wr_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
    n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL reset_pending got %b want 0", pending); end
    n_cmp++; if (swap_done !== 1'b0) begin n_bad++; $display("FAIL reset_swap_done got %b want 0", swap_done); end
    n_cmp++; if (line_en !== '0) begin n_bad++; $display("FAIL reset_line_en got %b want 0", line_en); end
    n_cmp++; if ({line_x1, line_x2, line_y1, line_y2} !== '0) begin
      n_bad++; $display("FAIL reset_line_xy got %h want 0", {line_x1, line_x2, line_y1, line_y2});
    end
  endtask

  task automatic test_basic_swap();
    int k;
    drive_write(2, 10, 20, 100, 200, 1);
    pulse_commit();
    n_cmp++; if (pending !== 1'b1) begin n_bad++; $display("FAIL commit_pending got %b want 1", pending); end
    n_cmp++; if (line_en !== 8'b0) begin n_bad++; $display("FAIL pre_swap_en got %b want 0", line_en); end
    pulse_frame_end();
    n_cmp++; if (swap_done !== 1'b1) begin n_bad++; $display("FAIL swap_done got %b want 1", swap_done); end
    n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL swap_pending got %b want 0", pending); end
    n_cmp++; if ({line_x1[2*WX +: WX], line_y1[2*WY +: WY], line_x2[2*WX +: WX], line_y2[2*WY +: WY]}
                 !== {10'd10, 9'd20, 10'd100, 9'd200}) begin
      n_bad++; $display("FAIL slot2_coords got %0d/%0d/%0d/%0d want 10/20/100/200",
        line_x1[2*WX +: WX], line_y1[2*WY +: WY], line_x2[2*WX +: WX], line_y2[2*WY +: WY]);
    end
    n_cmp++; if (line_en !== 8'b0000_0100) begin n_bad++; $display("FAIL slot2_en got %b want 00000100", line_en); end
    k = 0;
    while (wr_ready === 1'b0 && k < 20) begin
      tick();
      k++;
    end
    n_cmp++; if (k != N) begin n_bad++; $display("FAIL copy_busy_cycles got %0d want %0d", k, N); end
    n_cmp++; if (swap_done !== 1'b0) begin n_bad++; $display("FAIL swap_done_width got %b want 0", swap_done); end
  endtask

  task automatic test_clamp();
    drive_write(3, 1023, 511, 700, 500, 1);
    pulse_commit();
    pulse_frame_end();
    n_cmp++; if (line_x2[3*WX +: WX] !== 10'd639) begin n_bad++; $display("FAIL clamp_x2 got %0d want 639", line_x2[3*WX +: WX]); end
    n_cmp++; if (line_y2[3*WY +: WY] !== 9'd479) begin n_bad++; $display("FAIL clamp_y2 got %0d want 479", line_y2[3*WY +: WY]); end
    n_cmp++; if (line_x1[3*WX +: WX] !== 10'd639) begin n_bad++; $display("FAIL clamp_x1 got %0d want 639", line_x1[3*WX +: WX]); end
    n_cmp++; if (line_y1[3*WY +: WY] !== 9'd479) begin n_bad++; $display("FAIL clamp_y1 got %0d want 479", line_y1[3*WY +: WY]); end
    wait_fill();
  endtask

  task automatic test_incremental();
    drive_write(5, 1, 2, 3, 4, 1);
    pulse_commit();
    pulse_frame_end();
    n_cmp++; if ({line_x1[2*WX +: WX], line_y2[2*WY +: WY]} !== {10'd10, 9'd200}) begin
      n_bad++; $display("FAIL incr_slot2 got %0d/%0d want 10/200", line_x1[2*WX +: WX], line_y2[2*WY +: WY]);
    end
    n_cmp++; if ({line_x1[5*WX +: WX], line_y1[5*WY +: WY], line_x2[5*WX +: WX], line_y2[5*WY +: WY]}
                 !== {10'd1, 9'd2, 10'd3, 9'd4}) begin
      n_bad++; $display("FAIL incr_slot5 got %0d/%0d/%0d/%0d want 1/2/3/4",
        line_x1[5*WX +: WX], line_y1[5*WY +: WY], line_x2[5*WX +: WX], line_y2[5*WY +: WY]);
    end
    n_cmp++; if (line_en !== 8'b0010_1100) begin n_bad++; $display("FAIL incr_en got %b want 00101100", line_en); end
    wait_fill();
  endtask

  task automatic test_commit_with_frame_end();
    commit = 1'b1;
    frame_end = 1'b1;
    tick();
    commit = 1'b0;
    frame_end = 1'b0;
    n_cmp++; if (pending !== 1'b1) begin n_bad++; $display("FAIL cfe_pending got %b want 1", pending); end
    wr_valid = 1'b1; wr_idx = 3'd6;
    wr_x1 = 10'd77; wr_y1 = 9'd88; wr_x2 = 10'd99; wr_y2 = 9'd111; wr_en = 1'b1;
    tick();
    n_cmp++; if (swap_done !== 1'b0) begin n_bad++; $display("FAIL cfe_no_swap got %b want 0", swap_done); end
    tick();
    n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL cfe_ready_held got %b want 0", wr_ready); end
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    n_cmp++; if (swap_done !== 1'b1) begin n_bad++; $display("FAIL cfe_late_swap got %b want 1", swap_done); end
    n_cmp++; if (line_en[6] !== 1'b0) begin n_bad++; $display("FAIL cfe_held_write_early got %b want 0", line_en[6]); end
    wait_fill();
    tick();
    wr_valid = 1'b0;
    pulse_commit();
    pulse_frame_end();
    n_cmp++; if ({line_x1[6*WX +: WX], line_y1[6*WY +: WY], line_x2[6*WX +: WX], line_y2[6*WY +: WY], line_en[6]}
                 !== {10'd77, 9'd88, 10'd99, 9'd111, 1'b1}) begin
      n_bad++; $display("FAIL cfe_held_write got %0d/%0d/%0d/%0d en %b want 77/88/99/111 en 1",
        line_x1[6*WX +: WX], line_y1[6*WY +: WY], line_x2[6*WX +: WX], line_y2[6*WY +: WY], line_en[6]);
    end
    wait_fill();
  endtask

  task automatic test_reset_mid_copy();
    drive_write(4, 5, 6, 7, 8, 1);
    pulse_commit();
    pulse_frame_end();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL rmc_wr_ready got %b want 1", wr_ready); end
    n_cmp++; if (pending !== 1'b0 || swap_done !== 1'b0) begin
      n_bad++; $display("FAIL rmc_flags got pending %b swap_done %b want 0 0", pending, swap_done);
    end
    n_cmp++; if ({line_x1, line_x2, line_y1, line_y2, line_en} !== '0) begin
      n_bad++; $display("FAIL rmc_outputs got %h want 0", {line_x1, line_x2, line_y1, line_y2, line_en});
    end
    pulse_commit();
    pulse_frame_end();
    n_cmp++; if (line_en !== 8'b0) begin n_bad++; $display("FAIL rmc_back_cleared got %b want 0", line_en); end
    wait_fill();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      wr_valid  = 1'($urandom_range(0, 1));
      wr_idx    = 3'($urandom_range(0, 7));
      wr_x1     = WX'($urandom_range(0, 1023));
      wr_x2     = WX'($urandom_range(0, 1023));
      wr_y1     = WY'($urandom_range(0, 511));
      wr_y2     = WY'($urandom_range(0, 511));
      wr_en     = 1'($urandom_range(0, 1));
      commit    = ($urandom_range(0, 9) == 0);
      frame_end = ($urandom_range(0, 5) == 0);
      tick();
      n_cmp++; if (wr_ready !== (m_mode == 0)) begin n_bad++; $display("FAIL rnd_wr_ready cyc %0d got %b want %b", c, wr_ready, m_mode == 0); end
      n_cmp++; if (pending !== (m_mode == 1)) begin n_bad++; $display("FAIL rnd_pending cyc %0d got %b want %b", c, pending, m_mode == 1); end
      n_cmp++; if (swap_done !== (m_swap != 0)) begin n_bad++; $display("FAIL rnd_swap_done cyc %0d got %b want %b", c, swap_done, m_swap != 0); end
      n_cmp++; if (line_x1 !== exp_x1()) begin n_bad++; $display("FAIL rnd_x1 cyc %0d got %h want %h", c, line_x1, exp_x1()); end
      n_cmp++; if (line_x2 !== exp_x2()) begin n_bad++; $display("FAIL rnd_x2 cyc %0d got %h want %h", c, line_x2, exp_x2()); end
      n_cmp++; if (line_y1 !== exp_y1()) begin n_bad++; $display("FAIL rnd_y1 cyc %0d got %h want %h", c, line_y1, exp_y1()); end
      n_cmp++; if (line_y2 !== exp_y2()) begin n_bad++; $display("FAIL rnd_y2 cyc %0d got %h want %h", c, line_y2, exp_y2()); end
      n_cmp++; if (line_en !== exp_en()) begin n_bad++; $display("FAIL rnd_en cyc %0d got %b want %b", c, line_en, exp_en()); end
    end
    rst = 1'b0; wr_valid = 1'b0; commit = 1'b0; frame_end = 1'b0;
  endtask

  initial begin
    rst = 1'b1; frame_end = 1'b0; wr_valid = 1'b0; wr_idx = '0;
    wr_x1 = '0; wr_x2 = '0; wr_y1 = '0; wr_y2 = '0; wr_en = 1'b0; commit = 1'b0;
    m_mode = 0; m_busy = 0; m_swap = 0;
    test_reset();
    test_basic_swap();
    test_clamp();
    test_incremental();
    test_commit_with_frame_end();
    test_reset_mid_copy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/line_list_ctrl.md
# line_list_ctrl

Double-buffered display-list controller for the line renderers. Game logic writes line segments into a back bank through a valid/ready port. A commit makes the back bank visible at the next frame boundary. The front bank drives the endpoint inputs of `n_lines` line renderer instances, and their outputs are OR-ed at the top level. Slot contents never change while a frame is being scanned.

## Interface
- `screen_width`, 640, horizontal resolution.
- `screen_height`, 480, vertical resolution.
- `w_x`, `$clog2(screen_width)`, x coordinate width.
- `w_y`, `$clog2(screen_height)`, y coordinate width.
- `n_lines`, 8, number of slots and renderer instances (≥2).
- `w_idx`, `$clog2(n_lines)`, slot index width.

Ports:
- `clk`  in  1  pixel clock.
- `rst`  in  1  reset, synchronous, active-high.
- `frame_end`  in  1  one-cycle pulse; arrives ≥1 cycle before the renderers' `start_frame`.
- `wr_valid`  in  1  slot write request.
- `wr_ready`  out  1  write accepted when high together with `wr_valid`.
- `wr_idx`  in  `w_idx`  target slot.
- `wr_x1`, `wr_x2`  in  `w_x`  endpoint x.
- `wr_y1`, `wr_y2`  in  `w_y`  endpoint y.
- `wr_en`  in  1  slot visible flag.
- `commit`  in  1  one-cycle pulse: publish the back bank at the next `frame_end`.
- `pending`  out  1  a commit is waiting for `frame_end`.
- `swap_done`  out  1  one-cycle pulse after a swap.
- `line_x1`, `line_x2`  out  `n_lines*w_x`  front-bank x; slot i is at `[i*w_x +: w_x]`.
- `line_y1`, `line_y2`  out  `n_lines*w_y`  front-bank y; slot i is at `[i*w_y +: w_y]`.
- `line_en`  out  `n_lines`  front-bank visible flags.

## Operation
- **Storage:** two banks, each with `n_lines` slots of {x1, y1, x2, y2, en}. The `front` pointer bit selects the displayed bank; the other bank is the back bank.
- **FILL state:**
  - `wr_ready` = 1.
  - On a transfer, the back bank slot `wr_idx` is written.
  - x values greater than `screen_width-1` clamp to `screen_width-1`; y values are clamped the same way against `screen_height-1`.
  - If `wr_idx ≥ n_lines`, the transfer completes and the data is dropped.
  - `commit` moves the state to PENDING.
- **PENDING state:**
  - `wr_ready` = 0 and `pending` = 1.
  - `frame_end` toggles `front`, pulses `swap_done` and moves the state to COPY.
- **COPY state:**
  - `wr_ready` = 0.
  - A counter walks slots 0..`n_lines-1`, one per cycle, copying each front slot into the back bank. This makes the new back bank equal to what is on screen, so the next frame only needs incremental writes.
  - After the last slot the state returns to FILL.
- **Simultaneous events:**
  - `wr_valid`&`wr_ready`&`commit` in the same cycle: the write lands and is included in the commit.
  - `commit` and `frame_end` in the same FILL cycle: the state goes to PENDING, and the swap waits for the next `frame_end`.
  - `commit` outside FILL is ignored.
  - `frame_end` outside PENDING is ignored.
- **Reset:** from any state, including mid-COPY, `rst` does the following:
  - clears both banks to zero;
  - sets `front` = 0;
  - sets the state to FILL and clears the copy counter.

## Timing
- Reset values: `wr_ready`=1, `pending`=0, `swap_done`=0, all `line_*`=0, `line_en`=0.
- Write latency: a slot written at edge N is visible in back-bank storage after edge N. It does not reach `line_*` until a swap.
- `commit` sampled at edge N → `pending`=1 from the cycle after edge N.
- `frame_end` sampled in PENDING at edge N:
  - `front` toggles at edge N, so `line_*` shows the new bank from cycle N+1.
  - `swap_done`=1 and `pending`=0 during cycle N+1.
- COPY occupies exactly `n_lines` cycles, starting with cycle N+1. `wr_ready` returns to 1 in cycle N+1+`n_lines`.
- `line_*` and `line_en` are register or mux outputs of the front bank. They are stable except in the cycle after a swap.

## Structure
- Package `line_list_pkg`:
  - `typedef enum logic [1:0] {FILL, PENDING, COPY} list_state_t`;
  - the slot-field reset constant.
- Sub-module `line_list_bank`: two-bank slot register file with one write port, a bank-to-bank copy port and flattened front-bank outputs.
- The top level holds the FSM, the clamping logic, the copy counter and the handshake.

## Test plan
- Reset, then idle → `wr_ready`=1, `line_en`=0, all `line_*`=0, `pending`=0.
- Write slot 2 = (10,20)-(100,200) en=1, then `commit`, then `frame_end` → `swap_done` one cycle after `frame_end`; slot 2 outputs read 10/20/100/200 and `line_en`=8'b0000_0100.
- Write `wr_x2`=700 and `wr_y2`=500 → after the swap, `line_x2` slot = 639 and `line_y2` slot = 479.
- Swap → `wr_ready`=0 for exactly 8 cycles. Then write only slot 5 and commit again → after the second swap, slot 2 is unchanged and slot 5 is updated.
- `commit` and `frame_end` in the same FILL cycle → no swap; the swap happens at the following `frame_end`. A write held during PENDING waits until `wr_ready` returns.
- Assert `rst` in the 3rd COPY cycle → next cycle: FILL, `wr_ready`=1, all outputs 0.
